// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the initializer, shuffler and decryptor stages.
// Holds the default data width, the byte type and the PRGA state encoding.
package rc4_pkg;

  localparam int RAM_WIDTH = 8;

  typedef logic [RAM_WIDTH-1:0] byte_t;

  typedef enum logic [3:0] {
    IDLE,
    READ_I,
    WAIT_I,
    READ_J,
    WAIT_J,
    WRITE_I,
    WRITE_J,
    READ_F,
    WAIT_F,
    WRITE_OUT,
    DONE
  } prga_state_t;

endpackage

// File: rtl/ram_decryptor.sv
// RC4 PRGA stage: for each message byte, swaps S[i]/S[j] in the shared S RAM and
// writes keystream XOR encrypted ROM byte to the decrypted-message RAM (9 cycles per byte).
module ram_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = rc4_pkg::RAM_WIDTH,
  parameter int MSG_LENGTH = 32,
  localparam int MSG_AW    = (MSG_LENGTH > 1) ? $clog2(MSG_LENGTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 finished,
  input  logic [RAM_WIDTH-1:0] ram_out,
  output logic                 write_enable,
  output logic [RAM_WIDTH-1:0] ram_in,
  output logic [RAM_WIDTH-1:0] address,
  output logic [MSG_AW-1:0]    rom_address,
  input  logic [RAM_WIDTH-1:0] rom_data,
  output logic                 dec_write_enable,
  output logic [MSG_AW-1:0]    dec_address,
  output logic [RAM_WIDTH-1:0] dec_data
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LENGTH - 1);

  prga_state_t          state_reg, state_next;
  logic [RAM_WIDTH-1:0] i_reg, j_reg, si_reg, sj_reg, f_reg;
  logic [MSG_AW-1:0]    k_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      si_reg    <= '0;
      sj_reg    <= '0;
      f_reg     <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            i_reg <= RAM_WIDTH'(1);
            j_reg <= '0;
            k_reg <= '0;
          end
        end
        WAIT_I: begin
          si_reg <= ram_out;
          j_reg  <= j_reg + ram_out;
        end
        WAIT_J:    sj_reg <= ram_out;
        WAIT_F:    f_reg  <= ram_out;
        WRITE_OUT: begin
          i_reg <= i_reg + RAM_WIDTH'(1);
          k_reg <= k_reg + MSG_AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are a pure decode of state and datapath registers.
  always_comb begin
    state_next       = state_reg;
    finished         = 1'b0;
    write_enable     = 1'b0;
    ram_in           = '0;
    address          = '0;
    rom_address      = (state_reg == IDLE) ? '0 : k_reg;
    dec_write_enable = 1'b0;
    dec_address      = '0;
    dec_data         = '0;
    case (state_reg)
      IDLE:    if (start) state_next = READ_I;
      READ_I: begin
        address    = i_reg;
        state_next = WAIT_I;
      end
      WAIT_I:  state_next = READ_J;
      READ_J: begin
        address    = j_reg;
        state_next = WAIT_J;
      end
      WAIT_J:  state_next = WRITE_I;
      WRITE_I: begin
        address      = i_reg;
        ram_in       = sj_reg;
        write_enable = 1'b1;
        state_next   = WRITE_J;
      end
      WRITE_J: begin
        address      = j_reg;
        ram_in       = si_reg;
        write_enable = 1'b1;
        state_next   = READ_F;
      end
      READ_F: begin
        address    = si_reg + sj_reg;
        state_next = WAIT_F;
      end
      WAIT_F:  state_next = WRITE_OUT;
      WRITE_OUT: begin
        dec_write_enable = 1'b1;
        dec_address      = k_reg;
        dec_data         = f_reg ^ rom_data;
        state_next       = (k_reg == K_LAST) ? DONE : READ_I;
      end
      DONE: begin
        finished = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_decryptor.sv
// Bench for ram_decryptor: two instances (32-byte and 256-byte messages) with 1-cycle RAM/ROM
// models, checked against a plain RC4 KSA/PRGA reference computed inside the bench.
module tb_ram_decryptor;
  import rc4_pkg::*;

  localparam int LEN_A = 32;
  localparam int LEN_B = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, finished_a, write_enable_a, dec_write_enable_a;
  logic [7:0] ram_out_a, ram_in_a, address_a, rom_data_a, dec_data_a;
  logic [4:0] rom_address_a, dec_address_a;

  logic       start_b = 1'b0, finished_b, write_enable_b, dec_write_enable_b;
  logic [7:0] ram_out_b, ram_in_b, address_b, rom_data_b, dec_data_b;
  logic [7:0] rom_address_b, dec_address_b;

  ram_decryptor #(.RAM_WIDTH(8), .MSG_LENGTH(LEN_A)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .finished(finished_a),
    .ram_out(ram_out_a), .write_enable(write_enable_a), .ram_in(ram_in_a),
    .address(address_a), .rom_address(rom_address_a), .rom_data(rom_data_a),
    .dec_write_enable(dec_write_enable_a), .dec_address(dec_address_a), .dec_data(dec_data_a)
  );

  ram_decryptor #(.RAM_WIDTH(8), .MSG_LENGTH(LEN_B)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .finished(finished_b),
    .ram_out(ram_out_b), .write_enable(write_enable_b), .ram_in(ram_in_b),
    .address(address_b), .rom_address(rom_address_b), .rom_data(rom_data_b),
    .dec_write_enable(dec_write_enable_b), .dec_address(dec_address_b), .dec_data(dec_data_b)
  );

  // Memory models: read data valid the cycle after the address.
  byte_t s_init[256];
  byte_t s_mem_a[256], s_mem_b[256];
  byte_t rom_a[LEN_A], rom_b[LEN_B];
  byte_t dec_mem_a[LEN_A], dec_mem_b[LEN_B];
  logic  load_a = 1'b0, load_b = 1'b0;

  always @(posedge clk) begin
    if (load_a) for (int n = 0; n < 256; n++) s_mem_a[n] <= s_init[n];
    else if (write_enable_a) s_mem_a[address_a] <= ram_in_a;
    ram_out_a  <= s_mem_a[address_a];
    rom_data_a <= rom_a[rom_address_a];
    if (dec_write_enable_a) dec_mem_a[dec_address_a] <= dec_data_a;
  end

  always @(posedge clk) begin
    if (load_b) for (int n = 0; n < 256; n++) s_mem_b[n] <= s_init[n];
    else if (write_enable_b) s_mem_b[address_b] <= ram_in_b;
    ram_out_b  <= s_mem_b[address_b];
    rom_data_b <= rom_b[rom_address_b];
    if (dec_write_enable_b) dec_mem_b[dec_address_b] <= dec_data_b;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Reference RC4 state
  byte_t m_s[256];
  byte_t m_rom[256];
  byte_t exp_dec[256];

  task automatic ksa(input byte_t key[$]);
    int j;
    byte_t t;
    for (int n = 0; n < 256; n++) s_init[n] = byte_t'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + int'(s_init[n]) + int'(key[n % key.size()])) % 256;
      t = s_init[n]; s_init[n] = s_init[j]; s_init[j] = t;
    end
  endtask

  task automatic ref_prga(input int len);
    int i, j;
    byte_t t;
    for (int n = 0; n < 256; n++) m_s[n] = s_init[n];
    i = 0;
    j = 0;
    for (int k = 0; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      exp_dec[k] = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ m_rom[k];
    end
  endtask

  task automatic load_s(input bit use_b);
    @(negedge clk);
    if (use_b) load_b = 1'b1; else load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Raises start and counts edges (the sampling edge is edge 1) until finished is seen.
  task automatic run_dut(input bit use_b, output int edges, output int we_cnt,
                         output int dw_cnt, output int first_addr, output int first_rom);
    edges = 0; we_cnt = 0; dw_cnt = 0; first_addr = -1; first_rom = -1;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    while (edges < 4000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        first_addr = use_b ? int'(address_b) : int'(address_a);
        first_rom  = use_b ? int'(rom_address_b) : int'(rom_address_a);
      end
      if (use_b ? write_enable_b : write_enable_a) we_cnt++;
      if (use_b ? dec_write_enable_b : dec_write_enable_a) dw_cnt++;
      if (use_b ? finished_b : finished_a) break;
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_s_a(input string tag);
    int nmis = 0;
    for (int n = 0; n < 256; n++) if (s_mem_a[n] !== m_s[n]) nmis++;
    chk(tag, 64'(nmis), 64'd0);
  endtask

  task automatic check_dec_a(input string tag, input int from);
    for (int k = from; k < LEN_A; k++)
      chk($sformatf("%s_dec%0d", tag, k), 64'(dec_mem_a[k]), 64'(exp_dec[k]));
  endtask

  task automatic fill_rom_a(input bit randomize_all);
    for (int n = 0; n < LEN_A; n++) begin
      rom_a[n] = randomize_all ? byte_t'($urandom_range(0, 255)) : 8'h00;
      m_rom[n] = rom_a[n];
    end
  endtask

  byte_t key_q[$];
  byte_t ct[9];
  byte_t pt[9];
  int edges, we_cnt, dw_cnt, first_addr, first_rom, hold_err, nmis, nx;

  initial begin
    ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int n = 0; n < LEN_B; n++) rom_b[n] = 8'h00;
    fill_rom_a(1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_a", {finished_a, write_enable_a, ram_in_a, address_a, dec_write_enable_a,
                      dec_data_a, dec_address_a, rom_address_a}, 64'd0);
    chk("rst_out_b", {finished_b, write_enable_b, ram_in_b, address_b, dec_write_enable_b,
                      dec_data_b, dec_address_b, rom_address_b}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Identity S, zero ROM
    for (int n = 0; n < 256; n++) s_init[n] = byte_t'(n);
    fill_rom_a(1'b0);
    ref_prga(LEN_A);
    load_s(1'b0);
    run_dut(1'b0, edges, we_cnt, dw_cnt, first_addr, first_rom);
    chk("id_finished", 64'(finished_a), 64'd1);
    chk("id_edges", 64'(edges), 64'd289);
    chk("id_we_pulses", 64'(we_cnt), 64'd64);
    chk("id_dwe_pulses", 64'(dw_cnt), 64'd32);
    chk("id_first_addr", 64'(first_addr), 64'd1);
    chk("id_first_rom", 64'(first_rom), 64'd0);
    chk("id_dec0_const", 64'(dec_mem_a[0]), 64'h02);
    chk("id_dec1_const", 64'(dec_mem_a[1]), 64'h05);
    check_dec_a("id", 2);
    check_s_a("id_s_final");

    // Hold start in DONE, then drop it
    hold_err = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!finished_a || write_enable_a || dec_write_enable_a) hold_err++;
    end
    chk("hold_done", 64'(hold_err), 64'd0);
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_finished", 64'(finished_a), 64'd0);

    // "Key" / "Plaintext" vector, remaining ROM random; also checks restart from k=0, i=1
    key_q = '{8'h4B, 8'h65, 8'h79};
    ksa(key_q);
    fill_rom_a(1'b1);
    for (int n = 0; n < 9; n++) begin rom_a[n] = ct[n]; m_rom[n] = ct[n]; end
    ref_prga(LEN_A);
    load_s(1'b0);
    run_dut(1'b0, edges, we_cnt, dw_cnt, first_addr, first_rom);
    chk("pt_edges", 64'(edges), 64'd289);
    chk("pt_first_addr", 64'(first_addr), 64'd1);
    chk("pt_first_rom", 64'(first_rom), 64'd0);
    for (int n = 0; n < 9; n++)
      chk($sformatf("pt_const%0d", n), 64'(dec_mem_a[n]), 64'(pt[n]));
    check_dec_a("pt", 9);
    check_s_a("pt_s_final");
    drop_start();

    // Asynchronous reset in the middle of a run
    for (int n = 0; n < LEN_A; n++) dec_mem_a[n] = 8'h00;
    load_s(1'b0);
    @(negedge clk);
    start_a = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrun_reset_out", {finished_a, write_enable_a, ram_in_a, address_a, dec_write_enable_a,
                             dec_data_a, dec_address_a, rom_address_a}, 64'd0);
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ksa(key_q);
    load_s(1'b0);
    run_dut(1'b0, edges, we_cnt, dw_cnt, first_addr, first_rom);
    chk("rerun_edges", 64'(edges), 64'd289);
    for (int n = 0; n < 9; n++)
      chk($sformatf("rerun_const%0d", n), 64'(dec_mem_a[n]), 64'(pt[n]));
    check_s_a("rerun_s_final");
    drop_start();

    // Random keys and ciphertexts
    for (int r = 0; r < 3; r++) begin
      key_q.delete();
      for (int n = 0; n < int'($urandom_range(3, 16)); n++)
        key_q.push_back(byte_t'($urandom_range(0, 255)));
      ksa(key_q);
      fill_rom_a(1'b1);
      ref_prga(LEN_A);
      load_s(1'b0);
      run_dut(1'b0, edges, we_cnt, dw_cnt, first_addr, first_rom);
      chk($sformatf("rnd%0d_edges", r), 64'(edges), 64'd289);
      check_dec_a($sformatf("rnd%0d", r), 0);
      check_s_a($sformatf("rnd%0d_s_final", r));
      drop_start();
    end

    // 256-byte message: i wraps, k wraps back to 0
    for (int n = 0; n < 256; n++) begin s_init[n] = byte_t'(n); m_rom[n] = 8'h00; end
    ref_prga(LEN_B);
    load_s(1'b1);
    run_dut(1'b1, edges, we_cnt, dw_cnt, first_addr, first_rom);
    chk("wrap_edges", 64'(edges), 64'd2305);
    chk("wrap_dwe_pulses", 64'(dw_cnt), 64'd256);
    chk("wrap_we_pulses", 64'(we_cnt), 64'd512);
    chk("wrap_k_end", 64'(rom_address_b), 64'd0);
    nmis = 0;
    nx = 0;
    for (int k = 0; k < LEN_B; k++) begin
      if (dec_mem_b[k] !== exp_dec[k]) nmis++;
      if ($isunknown(dec_mem_b[k])) nx++;
    end
    chk("wrap_dec_mis", 64'(nmis), 64'd0);
    chk("wrap_dec_x", 64'(nx), 64'd0);
    nmis = 0;
    for (int n = 0; n < 256; n++) if (s_mem_b[n] !== m_s[n]) nmis++;
    chk("wrap_s_final", 64'(nmis), 64'd0);
    drop_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
